// File: rtl/l1_pkg.sv
// Shared L1 types: eviction FSM states and line geometry helpers.
package l1_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2
  } evict_state_e;

  // Bits needed to select a word within a line.
  function automatic int unsigned word_off_w(input int unsigned line_words);
    return $clog2(line_words);
  endfunction

  // Byte-offset bits within a line; these are cleared to form the line base address.
  function automatic int unsigned line_off_w(input int unsigned line_words, input int unsigned width);
    return $clog2(line_words * (width / 8));
  endfunction

endpackage

// File: rtl/l1_line_evict_if.sv
// Eviction request, data-array read port and write-back beat channel of l1_line_evict.
interface l1_line_evict_if #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned ADDR_W     = 32
);
  localparam int unsigned IDX_W   = $clog2(DEPTH / LINE_WORDS);
  localparam int unsigned RADDR_W = $clog2(DEPTH);

  logic               evict_req_val;
  logic               evict_req_rdy;
  logic [IDX_W-1:0]   evict_req_idx;
  logic [ADDR_W-1:0]  evict_req_addr;
  logic [RADDR_W-1:0] mem_raddr;
  logic [WIDTH-1:0]   mem_rdata;
  logic               wb_val;
  logic               wb_rdy;
  logic [ADDR_W-1:0]  wb_addr;
  logic [WIDTH-1:0]   wb_data;
  logic               wb_last;
  logic               evict_done;

  // master: the eviction engine (reads the array, drives write-back beats)
  modport master (
    input  evict_req_val, evict_req_idx, evict_req_addr, mem_rdata, wb_rdy,
    output evict_req_rdy, mem_raddr, wb_val, wb_addr, wb_data, wb_last, evict_done
  );

  // slave: controller, data array and next memory level around the engine
  modport slave (
    output evict_req_val, evict_req_idx, evict_req_addr, mem_rdata, wb_rdy,
    input  evict_req_rdy, mem_raddr, wb_val, wb_addr, wb_data, wb_last, evict_done
  );
endinterface

// File: rtl/l1_line_evict.sv
// Reads one L1 line word by word from the data array and streams it as a
// write-back burst, one address/data beat per accepted word.
module l1_line_evict
  import l1_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned ADDR_W     = 32
) (
  input logic          clk,
  input logic          rst,
  l1_line_evict_if.master bus
);

  localparam int unsigned IDX_W  = $clog2(DEPTH / LINE_WORDS);
  localparam int unsigned OFF_W  = word_off_w(LINE_WORDS);
  localparam int unsigned CNT_W  = OFF_W + 1;
  localparam int unsigned LOFF_W = line_off_w(LINE_WORDS, WIDTH);
  localparam int unsigned BYTES  = WIDTH / 8;
  localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W - LOFF_W){1'b1}}, {LOFF_W{1'b0}}};

  evict_state_e       state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic               wb_val_q, wb_val_d;
  logic [ADDR_W-1:0]  wb_addr_q, wb_addr_d;
  logic [WIDTH-1:0]   wb_data_q, wb_data_d;
  logic               wb_last_q, wb_last_d;
  logic               done_q, done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      base_q    <= '0;
      wb_val_q  <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      wb_last_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      base_q    <= base_d;
      wb_val_q  <= wb_val_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      wb_last_q <= wb_last_d;
      done_q    <= done_d;
    end
  end

  // Next-state and datapath; everything holds unless a transition updates it.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    base_d    = base_q;
    wb_val_d  = wb_val_q;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    wb_last_d = wb_last_q;
    done_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.evict_req_val) begin
          idx_d   = bus.evict_req_idx;
          base_d  = bus.evict_req_addr & LINE_MASK;
          cnt_d   = '0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        wb_data_d = bus.mem_rdata;
        wb_addr_d = base_q;
        wb_last_d = 1'b0;
        wb_val_d  = 1'b1;
        cnt_d     = CNT_W'(1);
        state_d   = ST_SEND;
      end
      ST_SEND: begin
        if (bus.wb_rdy) begin
          if (wb_last_q) begin
            wb_val_d = 1'b0;
            done_d   = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            wb_data_d = bus.mem_rdata;
            wb_addr_d = wb_addr_q + ADDR_W'(BYTES);
            wb_last_d = (cnt_q == CNT_W'(LINE_WORDS - 1));
            cnt_d     = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request acceptance only in IDLE, and never while reset is applied.
  assign bus.evict_req_rdy = (state_q == ST_IDLE) && !rst;
  assign bus.mem_raddr     = {idx_q, cnt_q[OFF_W-1:0]};
  assign bus.wb_val        = wb_val_q;
  assign bus.wb_addr       = wb_addr_q;
  assign bus.wb_data       = wb_data_q;
  assign bus.wb_last       = wb_last_q;
  assign bus.evict_done    = done_q;

endmodule
